kl8e_tx_fifo: RTL and testbench
===============================

// Module: kl8e_tx_fifo
// PURPOSE
//  Buffered console transmitter for the KL8E TTY path. Accepts characters from the
//  IOT decoder (TLS/TCP load pulses), queues them in a small FIFO and shifts them out
//  as 8N1/8N2 async serial on tx. Maintains the printer flag used by TSF/SPI/interrupt.
//  Drops in beside the receiver under the serial top level, with the same load/flag
//  handshake as the unbuffered transmitter.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock in Hz
//  BAUD       9600        line rate; bit period DIV = CLK_FREQ/BAUD clocks (integer divide)
//  DEPTH      8           FIFO entries; power of 2, >= 2
//  STOP_BITS  1           1 or 2 stop bits
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high
//  clear       in   1      CAF/console clear; same effect as reset
//  char        in   [0:11] AC; char[4:11] is the data byte, char[4] = MSB
//  load        in   1      level, may stay high for several clocks; rising edge = enqueue
//  clear_flag  in   1      level; clears flag (TCF/TLS)
//  set_flag    in   1      level; sets flag (SPF)
//  tx          out  1      serial line, idle high
//  flag        out  1      printer flag: "can accept another character"
//  fifo_count  out  $clog2(DEPTH)+1  entries waiting; excludes the char being shifted
// BEHAVIOUR
//  Reset/clear: FIFO emptied, FSM -> IDLE, tx=1, flag=0, rdy_req=0, fifo_count=0.
//   A character in flight is aborted at once; tx returns high on the next clock.
//  Load: enqueue char[4:11] on the clock after load goes 0->1 (registered edge detect).
//   Enqueue when fifo_count==DEPTH: byte discarded, count unchanged.
//   Any accepted or discarded load sets rdy_req.
//  Flag, evaluated each clock, highest priority first:
//   set_flag -> flag=1.
//   rdy_req && count_next<DEPTH -> flag=1, rdy_req=0.
//   clear_flag -> flag=0.
//   TLS asserts load and clear_flag together: flag drops, then rises once the entry is
//   queued and space remains. With the FIFO full, flag stays 0 until a pop frees a slot.
//  FSM:
//   IDLE: if FIFO not empty, pop into shift reg; -> START next clock.
//   START: tx=0 for DIV clocks.
//   DATA: 8 bits, LSB (char[11]) first, DIV clocks each.
//   STOP: tx=1 for STOP_BITS*DIV clocks; -> IDLE.
//   Pop happens in IDLE only, so back-to-back characters have one extra idle clock.
//  Latency: load edge to start-bit falling edge = 3 clocks when FIFO empty and FSM IDLE.
//  Simultaneous push and pop: both occur; count unchanged.
//  Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. The count register
//   distinguishes full from empty.
//  Baud counter runs only outside IDLE and reloads at every bit boundary.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> DIV=10, DEPTH=4)
//  1 Reset, then load 12'o0101 held 3 clocks -> exactly one frame:
//    start, bits 1,0,0,0,0,0,1,0, stop; 10 clocks per bit; flag=1 two clocks after edge.
//  2 Five load edges (TLS style, clear_flag with each) while idle -> 1st char in
//    shifter, 4 queued; flag=0 from the 5th load until the 1st pop; all 5 frames in order.
//  3 Sixth load while fifo_count==4 -> byte dropped; transmitted stream unchanged;
//    flag rises only when the next pop makes count 3.
//  4 set_flag and clear_flag high in same clock -> flag=1; clear_flag alone -> flag=0.
//  5 clear asserted mid DATA bit 3 -> tx=1 next clock, fifo_count=0, flag=0,
//    no further frames.
//  6 STOP_BITS=2, two chars queued -> stop high 20 clocks + 1 idle clock between frames.

Source files
------------

// File: rtl/kl8e_tx_fifo.sv
// ============================================================================
// kl8e_tx_fifo
// ----------------------------------------------------------------------------
// Buffered console transmitter for the KL8E TTY path. Characters loaded by the
// IOT decoder (TLS/TCP) are queued in a small FIFO and shifted out as 8N1/8N2
// asynchronous serial on o_tx. The printer flag ("can accept another
// character") is maintained here for TSF/SPI/interrupt use, with the same
// load/flag handshake as the unbuffered transmitter.
//
// Parameters
//   CLK_FREQ   system clock in Hz
//   BAUD       line rate; one bit lasts CLK_FREQ/BAUD clocks (integer divide)
//   DEPTH      FIFO entries, power of two, at least 2
//   STOP_BITS  1 or 2
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_clear        CAF/console clear, same effect as i_reset
//   i_char[0:11]   AC; i_char[4:11] is the data byte, i_char[4] is its MSB
//   i_load         level; each 0->1 transition enqueues one byte
//   i_clear_flag   level; clears the printer flag (TCF/TLS)
//   i_set_flag     level; sets the printer flag (SPF)
//   o_tx           serial line, idle high
//   o_flag         printer flag
//   o_fifo_count   entries waiting, not counting the byte being shifted
// ============================================================================
module kl8e_tx_fifo #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic [0:11]            i_char,
    input  logic                   i_load,
    input  logic                   i_clear_flag,
    input  logic                   i_set_flag,
    output logic                   o_tx,
    output logic                   o_flag,
    output logic [$clog2(DEPTH):0] o_fifo_count
);

    localparam int unsigned DIV     = CLK_FREQ / BAUD;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned BIT_RL  = DIV - 1;
    localparam int unsigned STOP_RL = STOP_BITS * DIV - 1;
    // Counter must hold the longest reload, which is the stop period.
    localparam int unsigned CW      = $clog2(STOP_BITS * DIV + 1);

    localparam logic [AW:0]   C_FULL    = DEPTH[AW:0];
    localparam logic [CW-1:0] C_BIT_RL  = BIT_RL[CW-1:0];
    localparam logic [CW-1:0] C_STOP_RL = STOP_RL[CW-1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          r_load_d;
    logic          r_load_pulse;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_rdy_req;
    logic          r_flag;
    logic [1:0]    r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_tx;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          w_rst;
    logic [7:0]    w_byte;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_next;
    logic          w_space_next;
    logic          w_rdy_consume;
    logic          w_baud_done;
    logic          w_unused_ac;

    assign w_rst   = i_reset | i_clear;
    // i_char[4] lands in w_byte[7]: AC bit 4 is the byte MSB.
    assign w_byte  = i_char[4:11];
    // AC bits 0..3 carry no data for the printer.
    assign w_unused_ac = ^i_char[0:3];

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

    // A load edge against a full FIFO is swallowed; it still raises rdy_req.
    assign w_push  = r_load_pulse & ~w_full;
    // Pops only happen while the shifter is idle, hence the one idle clock
    // between back-to-back frames.
    assign w_pop   = (r_state == S_IDLE) & ~w_empty;

    assign w_count_next = r_count
                        + {{AW{1'b0}}, w_push}
                        - {{AW{1'b0}}, w_pop};
    assign w_space_next = (w_count_next < C_FULL);

    // rdy_req is only consumed when it is the branch that actually sets the
    // flag; a simultaneous set_flag leaves it pending.
    assign w_rdy_consume = ~i_set_flag & r_rdy_req & w_space_next;

    assign w_baud_done = (r_baud_cnt == '0);

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: pointers and count define validity)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!w_rst && w_push) begin
            r_mem[r_wptr] <= w_byte;
        end
    end

    // ------------------------------------------------------------------
    // Load edge detect, FIFO pointers/count, printer flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            // Track load during reset so a level held across reset is not
            // mistaken for a fresh edge afterwards.
            r_load_d     <= i_load;
            r_load_pulse <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_rdy_req    <= 1'b0;
            r_flag       <= 1'b0;
        end else begin
            r_load_d     <= i_load;
            r_load_pulse <= i_load & ~r_load_d;

            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;

            if (i_set_flag) begin
                r_flag <= 1'b1;
            end else if (r_rdy_req && w_space_next) begin
                r_flag <= 1'b1;
            end else if (i_clear_flag) begin
                r_flag <= 1'b0;
            end

            r_rdy_req <= r_load_pulse | (r_rdy_req & ~w_rdy_consume);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM and baud counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rptr];
                        r_baud_cnt <= C_BIT_RL;
                        r_bit_cnt  <= '0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= C_BIT_RL;
                        r_bit_cnt  <= '0;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - CW'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_done) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_baud_cnt <= C_STOP_RL;
                            r_state    <= S_STOP;
                        end else begin
                            r_baud_cnt <= C_BIT_RL;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            r_shift    <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - CW'(1);
                    end
                end

                default: begin
                    if (w_baud_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line driver: registered from the current state, so the line trails the
    // FSM by one clock. Every period keeps its length; reset forces the line
    // high on the very next clock, aborting any frame in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign o_tx         = r_tx;
    assign o_flag       = r_flag;
    assign o_fifo_count = r_count;

endmodule

// File: tb/tb_kl8e_tx_fifo.sv
// ============================================================================
// tb_kl8e_tx_fifo
// Two transmitters (1 and 2 stop bits) share one stimulus stream. Each has a
// queue-based reference model that predicts line, flag and count per clock.
// ============================================================================
module tb_kl8e_tx_fifo;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 4;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        ld;
    logic        clf;
    logic        sf;
    logic [0:11] chr;
    bit          chk_en;

    int n_tests;
    int n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level at position k of a frame: start, 8 data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k < DIV)     return 1'b0;
        if (k < 9 * DIV) return b[(k / DIV) - 1];
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int SB = g + 1;
        localparam int L  = DIV * (9 + SB);

        logic       w_tx;
        logic       w_flag;
        logic [2:0] w_count;

        kl8e_tx_fifo #(
            .CLK_FREQ (CLK_FREQ),
            .BAUD     (BAUD),
            .DEPTH    (DEPTH),
            .STOP_BITS(SB)
        ) u_dut (
            .i_clk       (clk),
            .i_reset     (rst),
            .i_clear     (clr),
            .i_char      (chr),
            .i_load      (ld),
            .i_clear_flag(clf),
            .i_set_flag  (sf),
            .o_tx        (w_tx),
            .o_flag      (w_flag),
            .o_fifo_count(w_count)
        );

        // Reference model: queue of waiting bytes, remaining clocks of the
        // frame being sent, pending-ready request and the flag itself.
        logic [7:0] mq[$];
        int         m_rem  = 0;
        logic [7:0] m_cur  = 8'h00;
        bit         m_flag = 1'b0;
        bit         m_rdy  = 1'b0;
        bit         m_pend = 1'b0;
        bit         m_prev = 1'b0;
        bit         m_tx   = 1'b1;

        always @(posedge clk) begin : p_model
            int         n;
            int         cn;
            bit         idle;
            bit         pop;
            bit         push;
            logic [7:0] b;
            if (rst || clr) begin
                mq.delete();
                m_rem  = 0;
                m_flag = 1'b0;
                m_rdy  = 1'b0;
                m_pend = 1'b0;
                m_tx   = 1'b1;
            end else begin
                n    = mq.size();
                idle = (m_rem == 0);
                pop  = idle && (n > 0);
                push = m_pend && (n < DEPTH);
                cn   = n + int'(push) - int'(pop);
                m_tx = idle ? 1'b1 : frame_bit(m_cur, L - m_rem);
                if (!idle) m_rem = m_rem - 1;
                if (pop) begin
                    m_cur = mq.pop_front();
                    m_rem = L;
                end
                if (push) begin
                    b = chr[4:11];
                    mq.push_back(b);
                end
                if (sf) begin
                    m_flag = 1'b1;
                end else if (m_rdy && cn < DEPTH) begin
                    m_flag = 1'b1;
                    m_rdy  = 1'b0;
                end else if (clf) begin
                    m_flag = 1'b0;
                end
                if (m_pend) m_rdy = 1'b1;
                m_pend = ld && !m_prev;
            end
            m_prev = ld;
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("tx_sb%0d", SB), 32'(w_tx), 32'(m_tx));
                check($sformatf("flag_sb%0d", SB), 32'(w_flag), 32'(m_flag));
                check($sformatf("count_sb%0d", SB), 32'(w_count), 32'(mq.size()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : p_stim
        logic [0:9] pat;
        int         run0;
        int         run1;
        bit         end0;
        bit         end1;

        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst = 1'b1; clr = 1'b0; ld = 1'b0; clf = 1'b0; sf = 1'b0; chr = '0;
        cyc(3);
        chk_en = 1'b1;
        rst = 1'b0;
        cyc(2);
        check("reset_tx", 32'(g_cfg[0].w_tx), 32'd1);
        check("reset_flag", 32'(g_cfg[0].w_flag), 32'd0);
        check("reset_count", 32'(g_cfg[0].w_count), 32'd0);

        // 1: single character 0o0101 (byte 0x41), load held three clocks
        chr = 12'o0101; ld = 1'b1;          // N0
        cyc(2);                              // N2
        check("t1_flag_early", 32'(g_cfg[0].w_flag), 32'd0);
        cyc(1);                              // N3
        ld = 1'b0;
        check("t1_flag_rise", 32'(g_cfg[0].w_flag), 32'd1);
        check("t1_model_flag", 32'(g_cfg[0].m_flag), 32'd1);
        check("t1_tx_idle", 32'(g_cfg[0].w_tx), 32'd1);
        cyc(1);                              // N4
        check("t1_tx_start", 32'(g_cfg[0].w_tx), 32'd0);
        pat = 10'b0100000101;
        cyc(5);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t1_bit%0d_sb1", i), 32'(g_cfg[0].w_tx), 32'(pat[i]));
            check($sformatf("t1_bit%0d_sb2", i), 32'(g_cfg[1].w_tx), 32'(pat[i]));
            cyc(10);
        end
        cyc(150);

        // 2+3: six TLS-style loads; 1st goes to the shifter, 4 queue, 6th dropped
        for (int j = 0; j < 6; j++) begin
            ld = 1'b1; clf = 1'b1; chr = 12'($urandom);
            cyc(2);
            ld = 1'b0; clf = 1'b0;
            cyc(1);
        end                                  // now at N18
        check("t2_count_sb1", 32'(g_cfg[0].w_count), 32'd4);
        check("t2_count_sb2", 32'(g_cfg[1].w_count), 32'd4);
        check("t2_flag_full", 32'(g_cfg[0].w_flag), 32'd0);
        cyc(85);                             // N103
        check("t3_flag_before_pop", 32'(g_cfg[0].w_flag), 32'd0);
        cyc(1);                              // N104
        check("t3_flag_after_pop", 32'(g_cfg[0].w_flag), 32'd1);
        check("t3_count_after_pop", 32'(g_cfg[0].w_count), 32'd3);
        cyc(9);                              // N113
        check("t3_flag_before_pop_sb2", 32'(g_cfg[1].w_flag), 32'd0);
        cyc(1);                              // N114
        check("t3_flag_after_pop_sb2", 32'(g_cfg[1].w_flag), 32'd1);
        cyc(700);

        // 4: flag priority
        clf = 1'b1;
        cyc(1);
        check("t4_clear", 32'(g_cfg[0].w_flag), 32'd0);
        sf = 1'b1;
        cyc(1);
        check("t4_set_and_clear", 32'(g_cfg[0].w_flag), 32'd1);
        sf = 1'b0;
        cyc(1);
        check("t4_clear_again", 32'(g_cfg[0].w_flag), 32'd0);
        clf = 1'b0;
        cyc(2);

        // 5: clear during data bit 3 of byte 0xF0, one more byte queued
        chr = 12'h0F0; ld = 1'b1;            // N0
        cyc(1);
        ld = 1'b0;
        cyc(2);
        chr = 12'h0AA; ld = 1'b1;            // N3
        cyc(1);
        ld = 1'b0;
        cyc(44);                             // N48
        check("t5_tx_bit3", 32'(g_cfg[0].w_tx), 32'd0);
        check("t5_count_before", 32'(g_cfg[0].w_count), 32'd1);
        clr = 1'b1;
        cyc(1);                              // N49
        clr = 1'b0;
        check("t5_tx_abort", 32'(g_cfg[0].w_tx), 32'd1);
        check("t5_count_clear", 32'(g_cfg[0].w_count), 32'd0);
        check("t5_flag_clear", 32'(g_cfg[0].w_flag), 32'd0);
        cyc(200);
        check("t5_no_frames", 32'(g_cfg[1].w_tx), 32'd1);

        // 6: two bytes back to back; high run between frames is stop + 1 idle
        chr = 12'h055; ld = 1'b1;            // N0
        cyc(1);
        ld = 1'b0;
        cyc(1);
        chr = 12'h033; ld = 1'b1;            // N2
        cyc(1);
        ld = 1'b0;
        cyc(90);                             // N93
        check("t6_last_data_sb1", 32'(g_cfg[0].w_tx), 32'd0);
        check("t6_last_data_sb2", 32'(g_cfg[1].w_tx), 32'd0);
        cyc(1);                              // N94
        run0 = 0; run1 = 0; end0 = 1'b0; end1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!end0 && g_cfg[0].w_tx === 1'b1) run0++; else end0 = 1'b1;
            if (!end1 && g_cfg[1].w_tx === 1'b1) run1++; else end1 = 1'b1;
            cyc(1);
        end
        check("t6_gap_sb1", 32'(run0), 32'd11);
        check("t6_gap_sb2", 32'(run1), 32'd21);
        cyc(300);

        // Randomized traffic, including full-FIFO drops and stray clears
        repeat (4000) begin
            ld  = ($urandom_range(0, 3) == 0);
            clf = ld ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            sf  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 999) == 0);
            rst = ($urandom_range(0, 1999) == 0);
            chr = 12'($urandom);
            cyc(1);
        end
        ld = 1'b0; clf = 1'b0; sf = 1'b0; clr = 1'b0; rst = 1'b0;
        cyc(800);
        check("end_idle_sb1", 32'(g_cfg[0].w_tx), 32'd1);
        check("end_empty_sb2", 32'(g_cfg[1].w_count), 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
